texture_fetch: RTL and testbench

- Texture memory front-end between the rasterizer and a single-port synchronous texture SRAM macro.
- Serve mode: converts the rasterizer's 7-bit u/v texel coordinates into SRAM byte reads. Returns texel0/texel1 exactly one clock after the address, which is the latency the rasterizer expects.
- Load mode: a byte-stream loader FSM writes one 128x128 1-bit texture (2048 bytes) into either of two texture slots.

---
 rtl/texture_fetch.sv | 138 +++++++++++++
 tb/tb_texture_fetch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_fetch.sv
// Texture memory front-end: rasterizer texel reads and byte-stream
// texture loading over one single-port synchronous SRAM.
module texture_fetch #(
    parameter int TEX_DIM       = 128,
    parameter int BYTES_PER_TEX = 2048,
    parameter int ADDR_W        = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(TEX_DIM)-1:0]  u_addr,
    input  logic [$clog2(TEX_DIM)-1:0]  v_addr,
    input  logic                        tex_sel,
    input  logic                        rd_en,
    output logic                        texel0,
    output logic                        texel1,
    input  logic                        load_start,
    input  logic                        load_tex,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        load_busy,
    output logic                        load_done,
    output logic                        sram_cen,
    output logic                        sram_wen,
    output logic [ADDR_W-1:0]           sram_addr,
    output logic [7:0]                  sram_din,
    input  logic [7:0]                  sram_dout
);

    localparam int PTR_W = ADDR_W - 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BYTES_PER_TEX - 1);

    typedef enum logic {
        SERVE = 1'b0,
        LOAD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             slot_reg_q, slot_reg_d;
    logic             done_q, done_d;
    logic [2:0]       bit_q;
    logic             slot_q;
    logic             vld_q;
    logic             t;

    // Loader state, write pointer, target slot and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SERVE;
            wr_ptr_q   <= '0;
            slot_reg_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            slot_reg_q <= slot_reg_d;
            done_q     <= done_d;
        end
    end

    // Read pipeline: remember which bit/slot the SRAM byte belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q  <= 3'd0;
            slot_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            bit_q  <= u_addr[2:0];
            slot_q <= tex_sel;
            vld_q  <= rd_en & (state_q == SERVE);
        end
    end

    // Next-state: enter LOAD on start, leave after the final byte is written.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        slot_reg_d = slot_reg_q;
        done_d     = 1'b0;
        case (state_q)
            SERVE: begin
                if (load_start) begin
                    state_d    = LOAD;
                    slot_reg_d = load_tex;
                    wr_ptr_d   = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d = SERVE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = SERVE;
        endcase
    end

    // SRAM port mux: rasterizer reads in SERVE, stream writes in LOAD.
    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = '0;
        sram_din  = 8'h00;
        in_ready  = 1'b0;
        load_busy = 1'b0;
        if (!reset) begin
            case (state_q)
                SERVE: begin
                    if (rd_en) begin
                        sram_cen  = 1'b0;
                        sram_addr = {tex_sel, v_addr, u_addr[6:3]};
                    end
                end
                LOAD: begin
                    in_ready  = 1'b1;
                    load_busy = 1'b1;
                    if (in_valid) begin
                        sram_cen  = 1'b0;
                        sram_wen  = 1'b0;
                        sram_addr = {slot_reg_q, wr_ptr_q};
                        sram_din  = in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign t         = sram_dout[bit_q] & vld_q;
    assign texel0    = t & ~slot_q;
    assign texel1    = t & slot_q;
    assign load_done = done_q;

endmodule

// File: tb/tb_texture_fetch.sv
// Scoreboard bench for texture_fetch: texel and SRAM-write
// expectations are queued by stimulus and checked by monitors.
module tb_texture_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  u_addr, v_addr;
    logic        tex_sel, rd_en;
    logic        texel0, texel1;
    logic        load_start, load_tex, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, load_busy, load_done;
    logic        sram_cen, sram_wen;
    logic [11:0] sram_addr;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;

    logic [7:0]  mem [4096];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int    tag;
        logic  t0;
        logic  t1;
        string name;
    } tex_exp_t;

    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_exp_t;

    tex_exp_t tq[$];
    wr_exp_t  wq[$];
    tex_exp_t te;
    wr_exp_t  we;

    texture_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .u_addr    (u_addr),
        .v_addr    (v_addr),
        .tex_sel   (tex_sel),
        .rd_en     (rd_en),
        .texel0    (texel0),
        .texel1    (texel1),
        .load_start(load_start),
        .load_tex  (load_tex),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .load_busy (load_busy),
        .load_done (load_done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port SRAM model
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_din;
            else           sram_dout <= mem[sram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_tex(input string name, input logic t0,
                            input logic t1);
        tex_exp_t e;
        e.tag  = cyc + 1;
        e.t0   = t0;
        e.t1   = t1;
        e.name = name;
        tq.push_back(e);
    endtask

    // Texel monitor: compare each queued expectation in its cycle
    always @(negedge clk) begin
        while (tq.size() > 0 && tq[0].tag <= cyc) begin
            te = tq.pop_front();
            if (te.tag < cyc) begin
                chk({te.name, "_missed"}, 32'(te.tag), 32'(cyc));
            end else begin
                chk({te.name, "_texel0"}, 32'(texel0), 32'(te.t0));
                chk({te.name, "_texel1"}, 32'(texel1), 32'(te.t1));
            end
        end
    end

    // Write monitor: every SRAM write must match the next queued write
    always @(negedge clk) begin
        if (!reset) begin
            if (load_busy && !sram_cen)
                chk("load_no_read", 32'(sram_wen), 32'd0);
            if (!sram_cen && !sram_wen) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h expected none",
                             sram_addr, sram_din);
                end else begin
                    we = wq.pop_front();
                    chk("wr_addr", 32'(sram_addr), 32'(we.a));
                    chk("wr_data", 32'(sram_din), 32'(we.d));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic do_load(input logic slot, input int n,
                           input bit toggle, input bit noise);
        int i = 0;
        int k = 0;
        wr_exp_t w;
        load_start = 1'b1;
        load_tex   = slot;
        if (noise) begin
            rd_en   = 1'b1;
            u_addr  = 7'd8;
            v_addr  = 7'd0;
            tex_sel = 1'b0;
            push_tex("start_read", 1'b1, 1'b0);
        end
        tick;
        load_start = 1'b0;
        load_tex   = ~slot;
        rd_en      = 1'b0;
        chk("busy_in_load", 32'(load_busy), 32'd1);
        chk("ready_in_load", 32'(in_ready), 32'd1);
        while (i < n) begin
            in_valid = !(toggle && k[0]);
            in_data  = slot ? 8'hFF : i[7:0];
            if (noise) begin
                rd_en      = 1'b1;
                u_addr     = 7'($urandom);
                v_addr     = 7'($urandom);
                tex_sel    = 1'($urandom);
                load_start = (k % 37 == 5);
                push_tex("load_read", 1'b0, 1'b0);
            end
            if (in_valid) begin
                w.a = {slot, i[10:0]};
                w.d = in_data;
                wq.push_back(w);
                i++;
            end
            k++;
            tick;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        rd_en      = 1'b0;
    endtask

    task automatic rd(input string name, input logic [6:0] u,
                      input logic [6:0] v, input logic sel,
                      input logic [11:0] ea, input logic e0,
                      input logic e1);
        u_addr  = u;
        v_addr  = v;
        tex_sel = sel;
        rd_en   = 1'b1;
        #1;
        chk({name, "_addr"}, 32'(sram_addr), 32'(ea));
        chk({name, "_cen"}, 32'(sram_cen), 32'd0);
        chk({name, "_wen"}, 32'(sram_wen), 32'd1);
        push_tex(name, e0, e1);
        tick;
    endtask

    task automatic chk_done_pulse;
        chk("done_hi", 32'(load_done), 32'd1);
        chk("busy_lo", 32'(load_busy), 32'd0);
        chk("ready_lo", 32'(in_ready), 32'd0);
        tick;
        chk("done_lo", 32'(load_done), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        sram_dout  = 8'h00;
        reset      = 1'b1;
        u_addr     = 7'd8;
        v_addr     = 7'd0;
        tex_sel    = 1'b0;
        rd_en      = 1'b1;
        load_start = 1'b0;
        load_tex   = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        repeat (2) tick;
        chk("rst_texel0", 32'(texel0), 32'd0);
        chk("rst_texel1", 32'(texel1), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(load_busy), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_cen", 32'(sram_cen), 32'd1);
        chk("rst_wen", 32'(sram_wen), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_din", 32'(sram_din), 32'd0);
        reset = 1'b0;
        rd_en = 1'b0;
        tick;

        // Reset in the middle of a load
        do_load(1'b0, 100, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h64;
        rd_en    = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_texel0", 32'(texel0), 32'd0);
        chk("mid_rst_texel1", 32'(texel1), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_cen", 32'(sram_cen), 32'd1);
        chk("mid_rst_busy", 32'(load_busy), 32'd0);
        in_valid = 1'b0;
        rd_en    = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("post_rst_done", 32'(load_done), 32'd0);
            chk("post_rst_busy", 32'(load_busy), 32'd0);
        end

        // Full load of slot 0 with byte = address[7:0]
        do_load(1'b0, 2048, 1'b0, 1'b0);
        chk_done_pulse();

        // Directed reads from slot 0
        rd("r_u13", 7'd13, 7'd0, 1'b0, 12'h001, 1'b0, 1'b0);
        rd("r_u8", 7'd8, 7'd0, 1'b0, 12'h001, 1'b1, 1'b0);
        rd("r_u125", 7'd125, 7'd3, 1'b0, 12'h03F, 1'b1, 1'b0);
        rd("r_u127", 7'd127, 7'd3, 1'b0, 12'h03F, 1'b0, 1'b0);
        rd("r_u16", 7'd16, 7'd0, 1'b0, 12'h002, 1'b0, 1'b0);
        rd("r_u17", 7'd17, 7'd0, 1'b0, 12'h002, 1'b1, 1'b0);
        rd_en = 1'b0;
        tick;

        // Slot 1 load, toggled valid, reads and restarts during load
        do_load(1'b1, 2048, 1'b1, 1'b1);
        chk_done_pulse();

        rd("s1_a", 7'd0, 7'd0, 1'b1, 12'h800, 1'b0, 1'b1);
        rd("s1_b", 7'd77, 7'd99, 1'b1, 12'hE39, 1'b0, 1'b1);
        rd("s1_c", 7'd127, 7'd127, 1'b1, 12'hFFF, 1'b0, 1'b1);
        rd("s0_keep_a", 7'd8, 7'd0, 1'b0, 12'h001, 1'b1, 1'b0);
        rd("s0_keep_b", 7'd17, 7'd0, 1'b0, 12'h002, 1'b1, 1'b0);

        // Back-to-back sweeps across a row of each slot
        for (int u = 0; u < 128; u++) begin
            b = 8'(16 * 5 + u / 8);
            rd("sweep0", 7'(u), 7'd5, 1'b0, 12'(16 * 5 + u / 8),
               b[u % 8], 1'b0);
        end
        for (int u = 0; u < 128; u++) begin
            rd("sweep1", 7'(u), 7'd100, 1'b1,
               12'(2048 + 16 * 100 + u / 8), 1'b0, 1'b1);
        end
        rd_en = 1'b0;

        repeat (3) tick;
        chk("tex_queue_drained", 32'(tq.size()), 32'd0);
        chk("wr_queue_drained", 32'(wq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
